// File: rtl/pending_encoder_if.sv
// Request/grant bundle for pending_encoder.
// master drives requests and ready; slave is the encoder.
interface pending_encoder_if #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) ();
  logic [N-1:0] req;
  logic         enable;
  logic         out_ready;
  logic         out_valid;
  logic [W-1:0] out_idx;
  logic [N-1:0] pending;
  logic         busy;

  modport master (
    output req,
    output enable,
    output out_ready,
    input  out_valid,
    input  out_idx,
    input  pending,
    input  busy
  );

  modport slave (
    input  req,
    input  enable,
    input  out_ready,
    output out_valid,
    output out_idx,
    output pending,
    output busy
  );
endinterface

// File: rtl/pending_encoder.sv
// Buffered round-robin binary encoder: latches request pulses as
// pending bits and serializes them as indices on a valid/ready port.
module pending_encoder #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic             clk,
  input  logic             reset,
  pending_encoder_if.slave bus
);

  typedef enum logic {
    IDLE,
    HOLD
  } state_e;

  state_e       state_q, state_d;
  logic [N-1:0] pending_q, pending_d;
  logic [W-1:0] ptr_q, ptr_d;
  logic [W-1:0] idx_q, idx_d;

  logic [W-1:0] sel;
  logic         found;
  logic         load;
  logic [N-1:0] clear_mask;

  // Round-robin scan: first pending bit starting at ptr, wrapping mod N.
  always_comb begin
    logic [W-1:0] cand;
    sel   = ptr_q;
    found = 1'b0;
    cand  = ptr_q;
    for (int k = 0; k < N; k++) begin
      cand = ptr_q + W'(k);
      if (!found && pending_q[cand]) begin
        sel   = cand;
        found = 1'b1;
      end
    end
  end

  // Load only when the output slot is free or being retired this cycle.
  assign load = bus.enable && found &&
                ((state_q == IDLE) || bus.out_ready);

  // Next-state, grant bookkeeping and pending clear for the granted bit.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    ptr_d      = ptr_q;
    clear_mask = '0;
    unique case (state_q)
      IDLE: begin
        if (load) begin
          state_d         = HOLD;
          idx_d           = sel;
          ptr_d           = sel + W'(1);
          clear_mask[sel] = 1'b1;
        end
      end
      HOLD: begin
        if (load) begin
          idx_d           = sel;
          ptr_d           = sel + W'(1);
          clear_mask[sel] = 1'b1;
        end else if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A request arriving with its own grant wins, so OR after the clear.
  always_comb begin
    pending_d = (pending_q & ~clear_mask) | bus.req;
  end

  // State registers, cleared immediately by the asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      pending_q <= '0;
      ptr_q     <= '0;
      idx_q     <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      ptr_q     <= ptr_d;
      idx_q     <= idx_d;
    end
  end

  assign bus.out_valid = (state_q == HOLD);
  assign bus.out_idx   = idx_q;
  assign bus.pending   = pending_q;
  assign bus.busy      = (state_q == HOLD) || (|pending_q);

endmodule

// File: tb/tb_pending_encoder.sv
// Directed bench for pending_encoder with an index scoreboard.
// Expected indices are queued at stimulus time and popped on handshakes.
module tb_pending_encoder;

  localparam int N = 4;
  localparam int W = 2;

  logic clk;
  logic reset;
  int   checks;
  int   failures;
  int   exp_q[$];

  pending_encoder_if #(.N(N), .W(W)) bus_if ();

  pending_encoder #(.N(N), .W(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Consume n handshakes, comparing each presented index with the queue.
  // Request lines are cleared after the first cycle.
  task automatic drain(input int n, input string tag);
    int got;
    int cyc;
    got = 0;
    cyc = 0;
    while (got < n && cyc < 40) begin
      if (bus_if.out_valid === 1'b1 && bus_if.out_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk({tag, "_unexpected"}, 32'(bus_if.out_idx), 32'hFFFF);
        end else begin
          chk(tag, 32'(bus_if.out_idx), 32'(exp_q.pop_front()));
        end
        got++;
      end
      @(negedge clk);
      bus_if.req = '0;
      cyc++;
    end
    if (got < n) begin
      checks++;
      failures++;
      $error("FAIL %s_timeout observed=%0d expected=%0d", tag, got, n);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    bus_if.req = '0;
    exp_q.delete();
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    checks        = 0;
    failures      = 0;
    reset         = 1'b1;
    bus_if.req    = '0;
    bus_if.enable = 1'b1;
    bus_if.out_ready = 1'b1;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_valid", 32'(bus_if.out_valid), 0);
    chk("rst_idx", 32'(bus_if.out_idx), 0);
    chk("rst_pending", 32'(bus_if.pending), 0);
    chk("rst_busy", 32'(bus_if.busy), 0);
    reset = 1'b0;

    // Single request: two-edge latency
    @(negedge clk);
    bus_if.req = 4'b0100;
    exp_q.push_back(2);
    @(negedge clk);
    bus_if.req = '0;
    chk("single_pend", 32'(bus_if.pending), 32'h4);
    chk("single_notyet", 32'(bus_if.out_valid), 0);
    chk("single_busy", 32'(bus_if.busy), 1);
    @(negedge clk);
    chk("single_valid", 32'(bus_if.out_valid), 1);
    chk("single_pclr", 32'(bus_if.pending), 0);
    drain(1, "single_idx");
    chk("single_idle", 32'(bus_if.out_valid), 0);

    // Round-robin from reset
    do_reset();
    bus_if.req = 4'b1010;
    exp_q.push_back(1);
    exp_q.push_back(3);
    @(negedge clk);
    bus_if.req = '0;
    drain(2, "rr_a");
    chk("rr_a_idle", 32'(bus_if.out_valid), 0);
    bus_if.req = 4'b1111;
    for (int i = 0; i < 4; i++) exp_q.push_back(i);
    @(negedge clk);
    bus_if.req = '0;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      chk("rr_b_thru", 32'(bus_if.out_valid), 1);
      chk("rr_b_idx", 32'(bus_if.out_idx), 32'(exp_q.pop_front()));
      @(negedge clk);
    end
    chk("rr_b_idle", 32'(bus_if.out_valid), 0);
    chk("rr_b_pend", 32'(bus_if.pending), 0);

    // Backpressure (ptr is 0 here)
    bus_if.out_ready = 1'b0;
    bus_if.req = 4'b0010;
    exp_q.push_back(1);
    @(negedge clk);
    bus_if.req = '0;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 32'(bus_if.out_valid), 1);
      chk("bp_idx", 32'(bus_if.out_idx), 1);
      bus_if.req = (i == 1) ? 4'b1000 : 4'b0000;
      @(negedge clk);
    end
    chk("bp_pend", 32'(bus_if.pending), 32'h8);
    exp_q.push_back(3);
    bus_if.out_ready = 1'b1;
    drain(2, "bp_idx_rel");

    // Re-request collision with the grant of index 2 (ptr is 0)
    bus_if.req = 4'b0101;
    exp_q.push_back(0);
    exp_q.push_back(2);
    @(negedge clk);
    bus_if.req = '0;
    @(negedge clk);
    bus_if.req = 4'b0110;
    exp_q.push_back(1);
    exp_q.push_back(2);
    drain(4, "coll_idx");
    chk("coll_pend", 32'(bus_if.pending), 0);

    // Enable gating (ptr is 3)
    bus_if.enable = 1'b0;
    bus_if.req = 4'b0011;
    @(negedge clk);
    bus_if.req = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("en_valid", 32'(bus_if.out_valid), 0);
      chk("en_pend", 32'(bus_if.pending), 32'h3);
    end
    chk("en_busy", 32'(bus_if.busy), 1);
    bus_if.enable = 1'b1;
    exp_q.push_back(0);
    exp_q.push_back(1);
    drain(2, "en_idx");

    // Reset mid-operation: valid held, pending=1100, ptr=2
    bus_if.out_ready = 1'b0;
    bus_if.req = 4'b0010;
    @(negedge clk);
    bus_if.req = 4'b1100;
    @(negedge clk);
    bus_if.req = '0;
    @(negedge clk);
    chk("mid_valid", 32'(bus_if.out_valid), 1);
    chk("mid_idx", 32'(bus_if.out_idx), 1);
    chk("mid_pend", 32'(bus_if.pending), 32'hC);
    #2;
    reset = 1'b1;
    #1;
    chk("ar_valid", 32'(bus_if.out_valid), 0);
    chk("ar_idx", 32'(bus_if.out_idx), 0);
    chk("ar_pend", 32'(bus_if.pending), 0);
    chk("ar_busy", 32'(bus_if.busy), 0);
    @(negedge clk);
    reset = 1'b0;
    bus_if.out_ready = 1'b1;
    bus_if.req = 4'b1001;
    exp_q.push_back(0);
    exp_q.push_back(3);
    @(negedge clk);
    bus_if.req = '0;
    drain(2, "ar_rr");
    chk("ar_q_empty", 32'(exp_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
